modulo_alimentador_rolhas: RTL and testbench

- Transmitter end of the cork-transfer interface into the secondary cork buffer.
- On a request it latches a quantity and checks the 99-cork capacity. It then emits one clean, paced pulse per cork on `rolha_pulse`; the receiver's cork-entry counter clocks on this pulse.
- Reports `busy` / `done` / `erro_range` back to the control FSM. Sits between the operator request logic and the secondary-buffer receiver, clocked by the divided clock.

---
 rtl/modulo_alimentador_rolhas_pkg.sv | 17 +
 rtl/modulo_alimentador_rolhas_temporizador.sv | 34 +++
 rtl/modulo_alimentador_rolhas.sv | 165 ++++++++++++++++
 tb/tb_modulo_alimentador_rolhas.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/modulo_alimentador_rolhas_pkg.sv
// Shared definitions for the cork feeder: bus width, buffer capacity and
// the transfer FSM state encoding.
package modulo_alimentador_rolhas_pkg;

  localparam int W_BUS             = 7;
  localparam int CAPACIDADE_BUFFER = 99;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    VERIFICA = 3'd1,
    ALTO     = 3'd2,
    BAIXO    = 3'd3,
    FIM      = 3'd4,
    ERRO     = 3'd5
  } estado_e;

endpackage

// File: rtl/modulo_alimentador_rolhas_temporizador.sv
// Loadable down-counter timing one pulse phase (high or low). The caller
// loads (phase length - 1); fim_fase flags the last cycle of the phase.
module modulo_temporizador_fase
  import modulo_alimentador_rolhas_pkg::*;
#(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          carga,
  input  logic [TW-1:0] valor,
  output logic          fim_fase
);

  logic [TW-1:0] cnt_q, cnt_d;

  // next count: load wins, otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (carga)
      cnt_d = valor;
    else if (cnt_q != '0)
      cnt_d = cnt_q - TW'(1);
  end

  // counter register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign fim_fase = (cnt_q == '0);

endmodule

// File: rtl/modulo_alimentador_rolhas.sv
// Cork-transfer transmitter: accepts a request on a rising req edge,
// checks the secondary-buffer capacity and emits one paced, registered
// pulse per cork on rolha_pulse.
module modulo_alimentador_rolhas
  import modulo_alimentador_rolhas_pkg::*;
#(
  parameter int W          = W_BUS,
  parameter int CAPACIDADE = CAPACIDADE_BUFFER,
  parameter int T_ALTO     = 2,
  parameter int T_BAIXO    = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         req,
  input  logic [W-1:0] qtd_in,
  input  logic [W-1:0] nivel_atual,
  output logic         rolha_pulse,
  output logic         busy,
  output logic         done,
  output logic         erro_range,
  output logic [W-1:0] enviados
);

  localparam int T_MAX = (T_ALTO > T_BAIXO) ? T_ALTO : T_BAIXO;
  localparam int TW    = $clog2(T_MAX) + 1;

  estado_e       estado_q, estado_d;
  logic          req_q;
  logic          aceita_q, aceita_d;
  logic          cancela_q, cancela_d;
  logic [W-1:0]  qtd_q, qtd_d;
  logic [W-1:0]  nivel_q, nivel_d;
  logic [W-1:0]  env_q, env_d;
  logic          rolha_q, rolha_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          erro_q, erro_d;
  logic          carga;
  logic [TW-1:0] valor;
  logic          fim_fase;
  logic [W:0]    soma;

  // one extra bit so the capacity check never wraps
  assign soma = {1'b0, nivel_q} + {1'b0, qtd_q};

  modulo_temporizador_fase #(.TW(TW)) u_temporizador (
    .clk      (clk),
    .clr      (clr),
    .carga    (carga),
    .valor    (valor),
    .fim_fase (fim_fase)
  );

  // transfer FSM next-state and next-output logic
  always_comb begin
    estado_d  = estado_q;
    aceita_d  = 1'b0;
    cancela_d = cancela_q;
    qtd_d     = qtd_q;
    nivel_d   = nivel_q;
    env_d     = env_q;
    rolha_d   = rolha_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    erro_d    = 1'b0;
    carga     = 1'b0;
    valor     = TW'(T_ALTO - 1);
    case (estado_q)
      OCIOSO: begin
        if (aceita_q) begin
          qtd_d     = qtd_in;
          nivel_d   = nivel_atual;
          env_d     = '0;
          busy_d    = 1'b1;
          cancela_d = 1'b0;
          estado_d  = VERIFICA;
        end else if (req && !req_q) begin
          aceita_d = 1'b1;
        end
      end
      VERIFICA: begin
        if (soma > (W+1)'(CAPACIDADE)) begin
          estado_d = ERRO;
          erro_d   = 1'b1;
          busy_d   = 1'b0;
          env_d    = '0;
        end else if (qtd_q == '0) begin
          estado_d = FIM;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end else begin
          estado_d = ALTO;
          rolha_d  = 1'b1;
          carga    = 1'b1;
          valor    = TW'(T_ALTO - 1);
        end
      end
      ALTO: begin
        // a dropped request only ends the transfer after the current pulse
        if (!req) cancela_d = 1'b1;
        if (fim_fase) begin
          env_d    = env_q + W'(1);
          rolha_d  = 1'b0;
          estado_d = BAIXO;
          carga    = 1'b1;
          valor    = TW'(T_BAIXO - 1);
        end
      end
      BAIXO: begin
        if (!req) cancela_d = 1'b1;
        if (fim_fase) begin
          if (env_q == qtd_q || cancela_d) begin
            estado_d = FIM;
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end else begin
            estado_d = ALTO;
            rolha_d  = 1'b1;
            carga    = 1'b1;
            valor    = TW'(T_ALTO - 1);
          end
        end
      end
      FIM, ERRO: estado_d = OCIOSO;
      default:   estado_d = OCIOSO;
    endcase
  end

  // state and output registers; req edge register resets high so a req
  // already asserted at reset release is not seen as a new request
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      estado_q  <= OCIOSO;
      req_q     <= 1'b1;
      aceita_q  <= 1'b0;
      cancela_q <= 1'b0;
      qtd_q     <= '0;
      nivel_q   <= '0;
      env_q     <= '0;
      rolha_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      req_q     <= req;
      aceita_q  <= aceita_d;
      cancela_q <= cancela_d;
      qtd_q     <= qtd_d;
      nivel_q   <= nivel_d;
      env_q     <= env_d;
      rolha_q   <= rolha_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      erro_q    <= erro_d;
    end
  end

  assign rolha_pulse = rolha_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign erro_range  = erro_q;
  assign enviados    = env_q;

endmodule

// File: tb/tb_modulo_alimentador_rolhas.sv
// Bench for the cork feeder: directed and random transfers compared
// cycle by cycle against an expected waveform built from the timing rules.
module tb_modulo_alimentador_rolhas;

  localparam int W   = 7;
  localparam int TA  = 2;
  localparam int TBX = 2;
  localparam int CAP = 99;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         req = 1'b0;
  logic [W-1:0] qtd_in = '0;
  logic [W-1:0] nivel_atual = '0;
  logic         rolha_pulse, busy, done, erro_range;
  logic [W-1:0] enviados;

  int checks = 0;
  int failures = 0;
  int last_env = 0;

  modulo_alimentador_rolhas #(.W(W), .CAPACIDADE(CAP), .T_ALTO(TA), .T_BAIXO(TBX)) dut (
    .clk         (clk),
    .clr         (clr),
    .req         (req),
    .qtd_in      (qtd_in),
    .nivel_atual (nivel_atual),
    .rolha_pulse (rolha_pulse),
    .busy        (busy),
    .done        (done),
    .erro_range  (erro_range),
    .enviados    (enviados)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] pack(input bit r, input bit b, input bit d, input bit e, input int env);
    logic [W-1:0] ev;
    ev = W'(env);
    return {r, b, d, e, ev};
  endfunction

  task automatic chk(input string tag, input int idx, input logic [10:0] expv);
    logic [10:0] obs;
    obs = {rolha_pulse, busy, done, erro_range, enviados};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s[%0d] observed {pulse,busy,done,erro,env}=%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%0d",
             tag, idx, obs[10], obs[9], obs[8], obs[7], obs[6:0],
             expv[10], expv[9], expv[8], expv[7], expv[6:0]);
    end
  endtask

  // Full transfer: req edge, then every cycle compared with the waveform
  // implied by the rules (3-cycle latency, TA high / TBX low per cork,
  // done or erro one cycle after the last phase).
  task automatic transfer(input string tag, input int nivel, input int qtd, input int cancel_k);
    int n, L, per, p, ph, env;
    bit rej;
    logic [10:0] e;
    per = TA + TBX;
    rej = (nivel + qtd) > CAP;
    n   = rej ? 0 : ((cancel_k > 0 && cancel_k < qtd) ? cancel_k : qtd);
    L   = rej ? 3 : 3 + n * per;
    nivel_atual = W'(nivel);
    qtd_in      = W'(qtd);
    req         = 1'b1;
    for (int s = 1; s <= L; s++) begin
      step();
      if (s == 1)           e = pack(0, 0, 0, 0, last_env);
      else if (s == 2)      e = pack(0, 1, 0, 0, 0);
      else if (rej)         e = pack(0, 0, 0, 1, 0);
      else if (s == L)      e = pack(0, 0, 1, 0, n);
      else begin
        p   = (s - 3) / per;
        ph  = (s - 3) % per;
        env = (ph < TA) ? p : p + 1;
        e   = pack(ph < TA, 1, 0, 0, env);
      end
      chk(tag, s, e);
      // inputs are only sampled at acceptance; scramble them afterwards
      if (s == 2) begin
        qtd_in      = W'($urandom);
        nivel_atual = W'($urandom);
      end
      if (cancel_k > 0 && s == 3 + (cancel_k - 1) * per) req = 1'b0;
    end
    req = 1'b0;
    step();
    chk({tag, "_idle"}, 0, pack(0, 0, 0, 0, n));
    last_env = n;
    step();
  endtask

  initial begin
    int nv, qt, ck;
    // reset with req already high: nothing may start after release
    req = 1'b1;
    #12 clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_req_high", i, pack(0, 0, 0, 0, 0));
    end
    req = 1'b0;
    step();

    transfer("n10_q3", 10, 3, 0);
    transfer("n90_q9_cap", 90, 9, 0);
    transfer("n90_q10_err", 90, 10, 0);
    transfer("n50_q0", 50, 0, 0);
    transfer("n0_q127_err", 0, 127, 0);
    transfer("n0_q99_cap", 0, 99, 0);
    transfer("cancel_q20_k5", 0, 20, 5);

    // asynchronous reset in the middle of the third pulse of an 8-cork transfer
    nivel_atual = '0;
    qtd_in      = 7'd8;
    req         = 1'b1;
    for (int s = 1; s <= 3 + 2 * (TA + TBX); s++) step();
    chk("pre_abort", 0, pack(1, 1, 0, 0, 2));
    #2 clr = 1'b0;
    #1;
    chk("async_clr", 0, pack(0, 0, 0, 0, 0));
    @(posedge clk);
    #3 clr = 1'b1;
    req = 1'b0;
    step();
    chk("after_clr", 0, pack(0, 0, 0, 0, 0));
    last_env = 0;
    transfer("post_clr_q4", 20, 4, 0);

    // random transfers, some over capacity, some cancelled
    for (int i = 0; i < 25; i++) begin
      nv = int'($urandom_range(0, 99));
      qt = int'($urandom_range(0, 30));
      ck = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, qt + 1)) : 0;
      transfer("rand", nv, qt, ck);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
